acc_drain_ctrl: RTL

//  Reader side of the tile-accumulator interface: once a layer run finishes, walks every

---
 rtl/acc_drain_ctrl_pkg.sv | 28 ++
 rtl/acc_drain_ctrl_skid_buf.sv | 54 +++++
 rtl/acc_drain_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/acc_drain_ctrl_pkg.sv
// Shared definitions for the accumulator drain path: FSM encodings, tile index width
// and a signed saturation helper reused by writeback-side blocks.
package acc_drain_ctrl_pkg;

    // Tile index width matches acc_sel_tile on the accumulator bank.
    localparam int TILE_IDX_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Clamp a sign-extended value into the signed range of 'width' bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int width);
        logic signed [63:0] max_val;
        logic signed [63:0] min_val;
        max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_val = -(64'sd1 <<< (width - 1));
        if (value > max_val) begin
            return max_val;
        end else if (value < min_val) begin
            return min_val;
        end
        return value;
    endfunction

endpackage

// File: rtl/acc_drain_ctrl_skid_buf.sv
// Two-entry skid FIFO between the accumulator read pipe and the output port.
// Head entry is always mem0; push and pop may happen in the same cycle.
module drain_skid_buf #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            // NOTE: storage is reset as well; the head feeds the output port and must never carry X.
            mem0  <= '0;
            mem1  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        mem0 <= push_data;
                    end else begin
                        mem1 <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    mem0  <= mem1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        mem0 <= push_data;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = mem0;

endmodule

// File: rtl/acc_drain_ctrl.sv
// Accumulator drain controller: walks every tile/row after a layer run and streams the
// results out on a valid/ready port. Define DRAIN_SAT_EN for saturating narrowing.
module acc_drain_ctrl
    import acc_drain_ctrl_pkg::*;
#(
    parameter int NUM_TILES = 2,
    parameter int ROWS      = 4,
    parameter int ACC_W     = 32,
    parameter int DATA_W    = 16,
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  acc_rd_en,
    output logic [TILE_IDX_W-1:0] acc_rd_tile,
    output logic [ROW_W-1:0]      acc_rd_row,
    input  logic [ACC_W-1:0]      acc_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int                    ENTRY_W   = DATA_W + 1;
    localparam logic [TILE_IDX_W-1:0] LAST_TILE = TILE_IDX_W'(NUM_TILES - 1);
    localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(ROWS - 1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [TILE_IDX_W-1:0] tile_cnt;
    logic [ROW_W-1:0]      row_cnt;
    logic                  inflight;
    logic                  inflight_last;
    logic [1:0]            fifo_count;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [ENTRY_W-1:0]    fifo_wdata;
    logic [DATA_W-1:0]     conv_data;
    logic [2:0]            occupancy;
    logic                  pop;
    logic                  last_read;

`ifdef DRAIN_SAT_EN
    logic signed [63:0] sat_word;
    assign sat_word  = saturate(64'(signed'(acc_rd_data)), DATA_W);
    assign conv_data = DATA_W'(sat_word);
`else
    assign conv_data = DATA_W'(acc_rd_data);
`endif

    assign fifo_wdata = {inflight_last, conv_data};
    assign out_valid  = (fifo_count != 2'd0);
    assign out_data   = out_valid ? fifo_head[DATA_W-1:0] : '0;
    assign out_last   = out_valid && fifo_head[DATA_W];
    assign pop        = out_valid && out_ready;

    // Credit counts the slot freed by this cycle's pop, so a streaming sink sees one word per cycle.
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign acc_rd_en  = (state == ST_READ) && (occupancy < 3'd2);
    assign last_read  = (tile_cnt == LAST_TILE) && (row_cnt == LAST_ROW);

    assign acc_rd_tile = tile_cnt;
    assign acc_rd_row  = row_cnt;

    always_comb begin
        // NOTE: default assignment first keeps this always_comb free of inferred latches.
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_READ;
            ST_READ:  if (acc_rd_en && last_read) state_nxt = ST_FLUSH;
            ST_FLUSH: if (pop && out_last) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            tile_cnt      <= '0;
            row_cnt       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            busy          <= (state_nxt == ST_READ) || (state_nxt == ST_FLUSH);
            done          <= (state_nxt == ST_DONE);
            inflight      <= acc_rd_en;
            inflight_last <= acc_rd_en && last_read;
            if (acc_rd_en) begin
                if (row_cnt == LAST_ROW) begin
                    row_cnt  <= '0;
                    tile_cnt <= last_read ? '0 : tile_cnt + TILE_IDX_W'(1);
                end else begin
                    row_cnt <= row_cnt + ROW_W'(1);
                end
            end
        end
    end

    drain_skid_buf #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (fifo_wdata),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

endmodule
